// File: rtl/debug_request_sequencer_pkg.sv
// Shared debug definitions for the latch readout path.
//   state_e       : sequencer FSM encoding
//   IDLE_ID       : select value that matches no latch controller
//   CONTROLLER_ID : IDs of all debug latch instances. The chip top uses the
//                   same table when it instantiates the latch controllers.
package debug_request_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSelect  = 3'd1,
    StWaitWr  = 3'd2,
    StCapture = 3'd3,
    StRelease = 3'd4,
    StDrain   = 3'd5,
    StDone    = 3'd6
  } state_e;

  localparam logic [5:0] IDLE_ID = 6'h3F;

  localparam int unsigned N_LATCH = 4;
  localparam logic [5:0] CONTROLLER_ID [N_LATCH] = '{6'd0, 6'd1, 6'd2, 6'd3};

endpackage

// File: rtl/debug_frame_fifo.sv
// Single-clock frame buffer between the latch frame bus and the transmit side.
//   i_clock, i_reset_n : clock, synchronous active-low reset (flushes pointers)
//   i_push, i_data     : write request and data; dropped when full unless a
//                        pop happens in the same cycle
//   o_full             : no free slot
//   i_pop, o_data      : read request and current head (combinational read)
//   o_empty            : no stored frame
module debug_frame_fifo #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_push,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_full,
  input  logic               i_pop,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_empty
);

  localparam int unsigned NB_ADDR = $clog2(DEPTH);
  localparam logic [NB_ADDR:0] PTR_ONE = (NB_ADDR + 1)'(1);

  if (DEPTH < 2 || (1 << NB_ADDR) != DEPTH) begin : g_bad_depth
    $error("debug_frame_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [NB_ADDR:0]   wr_ptr_q, rd_ptr_q;
  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic               push_ok, pop_ok;

  // One extra pointer bit separates full from empty when the addresses match.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[NB_ADDR] != rd_ptr_q[NB_ADDR]) &&
                   (wr_ptr_q[NB_ADDR-1:0] == rd_ptr_q[NB_ADDR-1:0]);
  assign pop_ok  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = i_push && (!o_full || pop_ok);
  assign o_data  = mem_q[rd_ptr_q[NB_ADDR-1:0]];

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push_ok) mem_q[wr_ptr_q[NB_ADDR-1:0]] <= i_data;
  end

endmodule

// File: rtl/debug_request_sequencer.sv
// Walks N_CTRL debug latch controllers over the shared select bus, captures
// the frames each streams back, buffers them and offers them to the debug
// transmitter over valid/ready.
//   i_clock, i_reset_n : clock, synchronous active-low reset
//   i_start            : starts a sequence when idle
//   o_request_select   : registered controller ID (IDLE_ID between controllers)
//   i_writing, i_frame : frame stream from the selected controller
//   o_frame, o_frame_valid, i_frame_ready : buffered frame handshake
//   o_busy, o_done     : sequence in progress / one-cycle completion pulse
//   o_timeout_mask     : controllers that never answered in the last sequence
//   o_overflow         : sticky, a frame was dropped on a full buffer
module debug_request_sequencer
  import debug_request_sequencer_pkg::*;
#(
  parameter int unsigned         NB_CONTROL_FRAME = 32,
  parameter int unsigned         NB_ID            = 6,
  parameter int unsigned         N_CTRL           = 4,
  parameter logic [NB_ID-1:0]    BASE_ID          = NB_ID'(debug_request_sequencer_pkg::CONTROLLER_ID[0]),
  parameter logic [NB_ID-1:0]    IDLE_ID          = NB_ID'(debug_request_sequencer_pkg::IDLE_ID),
  parameter int unsigned         FIFO_DEPTH       = 8,
  parameter int unsigned         NB_TIMEOUT       = 8,
  parameter int unsigned         TIMEOUT          = 255
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_start,
  output logic [NB_ID-1:0]            o_request_select,
  input  logic                        i_writing,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame,
  output logic [NB_CONTROL_FRAME-1:0] o_frame,
  output logic                        o_frame_valid,
  input  logic                        i_frame_ready,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [N_CTRL-1:0]           o_timeout_mask,
  output logic                        o_overflow
);

  localparam int unsigned            NB_INDEX     = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
  localparam logic [NB_INDEX-1:0]    LAST_INDEX   = NB_INDEX'(N_CTRL - 1);
  localparam logic [NB_TIMEOUT-1:0]  TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT - 1);

  // The walked ID range must never contain the idle select value.
  if ((int'(IDLE_ID) >= int'(BASE_ID)) &&
      (int'(IDLE_ID) <= int'(BASE_ID) + int'(N_CTRL) - 1)) begin : g_bad_id_range
    $error("debug_request_sequencer: BASE_ID..BASE_ID+N_CTRL-1 reaches IDLE_ID");
  end
  if (N_CTRL < 1 || TIMEOUT < 1 || TIMEOUT > (1 << NB_TIMEOUT)) begin : g_bad_counts
    $error("debug_request_sequencer: N_CTRL/TIMEOUT out of range");
  end

  state_e                  state_q, state_d;
  logic [NB_INDEX-1:0]     index_q, index_d;
  logic [NB_TIMEOUT-1:0]   count_q, count_d;
  logic [NB_ID-1:0]        select_q, select_d;
  logic [N_CTRL-1:0]       mask_q, mask_d;
  logic                    overflow_q, overflow_d;

  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign o_frame_valid = !fifo_empty;
  assign pop           = o_frame_valid && i_frame_ready;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    count_d    = count_q;
    mask_d     = mask_q;
    overflow_d = overflow_q;
    push       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          index_d    = '0;
          mask_d     = '0;
          overflow_d = 1'b0;
          state_d    = StSelect;
        end
      end
      StSelect: begin
        count_d = '0;
        state_d = StWaitWr;
      end
      StWaitWr: begin
        if (i_writing) begin
          push    = 1'b1;
          state_d = StCapture;
        end else if (count_q == TIMEOUT_LAST) begin
          mask_d[index_q] = 1'b1;
          state_d         = StRelease;
        end else begin
          count_d = count_q + NB_TIMEOUT'(1);
        end
      end
      StCapture: begin
        if (i_writing) begin
          push = 1'b1;
        end else begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StDrain;
      end
      StDrain: begin
        // Next ID is only issued once everything from this controller left.
        if (fifo_empty) begin
          if (index_q == LAST_INDEX) begin
            state_d = StDone;
          end else begin
            index_d = index_q + NB_INDEX'(1);
            state_d = StSelect;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (push && fifo_full && !pop) overflow_d = 1'b1;

    // Select follows the state being entered so the bus is registered.
    if (state_d == StSelect || state_d == StWaitWr || state_d == StCapture) begin
      select_d = BASE_ID + NB_ID'(index_d);
    end else begin
      select_d = IDLE_ID;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      index_q    <= '0;
      count_q    <= '0;
      select_q   <= IDLE_ID;
      mask_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      count_q    <= count_d;
      select_q   <= select_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_request_select = select_q;
  assign o_busy           = (state_q != StIdle);
  assign o_done           = (state_q == StDone);
  assign o_timeout_mask   = mask_q;
  assign o_overflow       = overflow_q;

  debug_frame_fifo #(
    .NB_DATA (NB_CONTROL_FRAME),
    .DEPTH   (FIFO_DEPTH)
  ) u_frame_fifo (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_push    (push),
    .i_data    (i_frame),
    .o_full    (fifo_full),
    .i_pop     (pop),
    .o_data    (o_frame),
    .o_empty   (fifo_empty)
  );

endmodule

// File: tb/tb_debug_request_sequencer.sv
module tb_debug_request_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Main instance: two controllers, 8-deep buffer.
  logic        m_start = 1'b0, m_writing = 1'b0, m_ready = 1'b1;
  logic [31:0] m_frame_in = '0;
  logic [5:0]  m_sel;
  logic [31:0] m_frame;
  logic        m_valid, m_busy, m_done, m_overflow;
  logic [1:0]  m_mask;

  // Small instance: one controller, 2-deep buffer for overflow.
  logic        s_start = 1'b0, s_writing = 1'b0, s_ready = 1'b0;
  logic [31:0] s_frame_in = '0;
  logic [5:0]  s_sel;
  logic [31:0] s_frame;
  logic        s_valid, s_busy, s_done, s_overflow;
  logic [0:0]  s_mask;

  debug_request_sequencer #(
    .N_CTRL     (2),
    .FIFO_DEPTH (8)
  ) dut (
    .i_clock          (clock),
    .i_reset_n        (reset_n),
    .i_start          (m_start),
    .o_request_select (m_sel),
    .i_writing        (m_writing),
    .i_frame          (m_frame_in),
    .o_frame          (m_frame),
    .o_frame_valid    (m_valid),
    .i_frame_ready    (m_ready),
    .o_busy           (m_busy),
    .o_done           (m_done),
    .o_timeout_mask   (m_mask),
    .o_overflow       (m_overflow)
  );

  debug_request_sequencer #(
    .N_CTRL     (1),
    .FIFO_DEPTH (2)
  ) dut_small (
    .i_clock          (clock),
    .i_reset_n        (reset_n),
    .i_start          (s_start),
    .o_request_select (s_sel),
    .i_writing        (s_writing),
    .i_frame          (s_frame_in),
    .o_frame          (s_frame),
    .o_frame_valid    (s_valid),
    .i_frame_ready    (s_ready),
    .o_busy           (s_busy),
    .o_done           (s_done),
    .o_timeout_mask   (s_mask),
    .o_overflow       (s_overflow)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct packed {
    logic        start;
    logic        writing;
    logic [31:0] frame;
    logic        ready;
    logic [5:0]  sel;
    logic        valid;
    logic [31:0] dout;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs [15];
  logic [31:0] f4 [4];
  int n;
  int done_count;

  initial begin
    // Two-controller walk: ctrl0 sends 1 frame, ctrl1 sends 2. Extra starts
    // while busy and writing outside WAIT_WR/CAPTURE must be ignored.
    //             start writing frame         ready sel    valid dout          busy done
    vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 6'h3F, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'hAAAA0001,  1'b1, 6'h00, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 6'h00, 1'b1, 32'hAAAA0001,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 6'h3F, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 6'h3F, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'hDEAD0000,  1'b1, 6'h01, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'hBBBB0001,  1'b1, 6'h01, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'hBBBB0002,  1'b1, 6'h01, 1'b1, 32'hBBBB0001,  1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 6'h01, 1'b1, 32'hBBBB0002,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'hDEAD0001,  1'b1, 6'h3F, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 6'h3F, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 6'h3F, 1'b0, 32'h0,         1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 6'h3F, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 6'h3F, 1'b0, 32'h0,         1'b0, 1'b0};
    f4[0] = 32'hC0DE0000; f4[1] = 32'hC0DE0001; f4[2] = 32'hC0DE0002; f4[3] = 32'hC0DE0003;

    // Reset state.
    reset_n = 1'b0;
    step();
    step();
    check("reset_sel", 32'(m_sel), 32'h3F);
    check("reset_busy", 32'(m_busy), 0);
    check("reset_valid", 32'(m_valid), 0);
    check("reset_done", 32'(m_done), 0);
    check("reset_mask", 32'(m_mask), 0);
    check("reset_ovf", 32'(m_overflow), 0);
    reset_n = 1'b1;

    // Table-driven two-controller walk.
    done_count = 0;
    for (int i = 0; i < 15; i++) begin
      m_start    = vecs[i].start;
      m_writing  = vecs[i].writing;
      m_frame_in = vecs[i].frame;
      m_ready    = vecs[i].ready;
      check($sformatf("v%0d_sel", i), 32'(m_sel), 32'(vecs[i].sel));
      check($sformatf("v%0d_valid", i), 32'(m_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) check($sformatf("v%0d_frame", i), m_frame, vecs[i].dout);
      check($sformatf("v%0d_busy", i), 32'(m_busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_done", i), 32'(m_done), 32'(vecs[i].done));
      if (m_done) done_count++;
      step();
    end
    m_start = 1'b0;
    check("walk_done_count", 32'(done_count), 1);
    check("walk_mask", 32'(m_mask), 0);

    // Timeout: ctrl0 sends one frame, ctrl1 stays silent.
    m_ready = 1'b1;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    step();
    m_writing = 1'b1;
    m_frame_in = 32'h12345678;
    step();
    m_writing = 1'b0;
    check("to_frame", m_frame, 32'h12345678);
    n = 0;
    while (m_sel != 6'h01 && n < 20) begin step(); n++; end
    check("to_reach_sel1", 32'(m_sel), 32'h01);
    // One SELECT cycle followed by TIMEOUT waiting cycles.
    n = 0;
    while (m_sel == 6'h01 && n < 400) begin step(); n++; end
    check("to_sel1_cycles", 32'(n), 256);
    check("to_mask_set", 32'(m_mask), 32'h2);
    n = 0;
    while (!m_done && n < 20) begin step(); n++; end
    check("to_done", 32'(m_done), 1);
    check("to_mask_final", 32'(m_mask), 32'h2);
    step();
    check("to_idle", 32'(m_busy), 0);

    // Overflow on the 2-deep instance: third frame is dropped.
    s_ready = 1'b0;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("ov_sel", 32'(s_sel), 32'h00);
    step();
    s_writing = 1'b1; s_frame_in = 32'h11110001;
    step();
    s_frame_in = 32'h11110002;
    step();
    s_frame_in = 32'h11110003;
    check("ov_before_drop", 32'(s_overflow), 0);
    step();
    s_writing = 1'b0;
    check("ov_set", 32'(s_overflow), 1);
    check("ov_head", s_frame, 32'h11110001);
    step();
    step();
    s_ready = 1'b1;
    check("ov_pop0", s_frame, 32'h11110001);
    step();
    check("ov_pop1", s_frame, 32'h11110002);
    step();
    check("ov_empty", 32'(s_valid), 0);
    n = 0;
    while (!s_done && n < 10) begin step(); n++; end
    check("ov_done", 32'(s_done), 1);
    check("ov_sticky_done", 32'(s_overflow), 1);
    step();
    check("ov_sticky_idle", 32'(s_overflow), 1);
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    check("ov_cleared_by_start", 32'(s_overflow), 0);

    // Back-pressure: four frames held while ready=0, DRAIN waits for pops.
    m_ready = 1'b0;
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    check("bp_mask_cleared", 32'(m_mask), 0);
    step();
    for (int k = 0; k < 4; k++) begin
      m_writing = 1'b1;
      m_frame_in = f4[k];
      step();
    end
    m_writing = 1'b0;
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      check("bp_hold_valid", 32'(m_valid), 1);
      check("bp_hold_frame", m_frame, f4[0]);
      check("bp_hold_sel", 32'(m_sel), 32'h3F);
      step();
    end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_pop%0d", k), m_frame, f4[k]);
      check("bp_pop_sel", 32'(m_sel), 32'h3F);
      step();
    end
    check("bp_empty", 32'(m_valid), 0);
    n = 0;
    while (m_sel != 6'h01 && n < 4) begin step(); n++; end
    check("bp_next_sel", 32'(m_sel), 32'h01);

    // Reset in CAPTURE with two frames buffered.
    m_ready = 1'b0;
    step();
    m_writing = 1'b1; m_frame_in = 32'hE0000000;
    step();
    m_frame_in = 32'hE0000001;
    step();
    check("rst_buffered", m_frame, 32'hE0000000);
    m_frame_in = 32'hE0000002;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m_writing = 1'b0;
    check("rst_sel", 32'(m_sel), 32'h3F);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_busy", 32'(m_busy), 0);
    check("rst_ovf", 32'(m_overflow), 0);
    check("rst_small_busy", 32'(s_busy), 0);
    check("rst_small_mask", 32'(s_mask), 0);

    // After reset the walk restarts at the first controller.
    m_start = 1'b1;
    step();
    m_start = 1'b0;
    check("restart_sel", 32'(m_sel), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_request_sequencer.md
Name: debug_request_sequencer

Overview:
Sequences the debug readout of N_CTRL debug latch controllers that share one request-select bus and one frame bus. On a start pulse it selects each controller ID in turn and captures the frames the controller streams, one per clock. It buffers those frames in a FIFO and hands them to the debug transmit interface over a valid/ready handshake. It sits between the debug latch controllers and the UART framing logic, and flags controllers that never respond.

Parameters:
NB_CONTROL_FRAME, 32, width of one frame.
NB_ID, 6, width of a controller ID.
N_CTRL, 4, number of controllers walked per sequence; IDs are BASE_ID..BASE_ID+N_CTRL-1.
BASE_ID, 6'b000000, ID of the first controller.
IDLE_ID, 6'b111111, select value that matches no controller.
FIFO_DEPTH, 8, frame buffer depth; power of 2; must be >= the largest frame count of any controller.
NB_TIMEOUT, 8, timeout counter width.
TIMEOUT, 255, cycles to wait for i_writing before skipping a controller.

Ports:
i_clock  in  1  single clock, all logic on rising edge.
i_reset_n  in  1  synchronous active-low reset.
i_start  in  1  one-cycle pulse that starts a sequence; ignored while o_busy=1.
o_request_select  out  NB_ID  ID driven to all controllers.
i_writing  in  1  OR of the controllers' writing flags.
i_frame  in  NB_CONTROL_FRAME  muxed frame from the controllers; valid while i_writing=1.
o_frame  out  NB_CONTROL_FRAME  FIFO head.
o_frame_valid  out  1  FIFO not empty.
i_frame_ready  in  1  consumer accepts o_frame when valid&ready.
o_busy  out  1  high whenever the state is not IDLE.
o_done  out  1  one-cycle pulse when a sequence completes.
o_timeout_mask  out  N_CTRL  bit k set if controller k timed out in the last sequence.
o_overflow  out  1  sticky; a frame was dropped because the FIFO was full.

Behaviour:
- Reset (i_reset_n=0 at a clock edge), applicable at any time, including mid-sequence:
  - state=IDLE, o_request_select=IDLE_ID, FIFO flushed, o_frame_valid=0.
  - o_busy=0, o_done=0, o_timeout_mask=0, o_overflow=0, index=0, timeout counter=0.
- States: IDLE, SELECT, WAIT_WR, CAPTURE, RELEASE, DRAIN, DONE. o_request_select is registered.
- IDLE: select=IDLE_ID. i_start=1 -> index=0, o_timeout_mask cleared, o_overflow cleared, go to SELECT.
- SELECT: select=BASE_ID+index, timeout counter=0, go to WAIT_WR next cycle.
- WAIT_WR: select held.
  - i_writing=1 -> push i_frame, go to CAPTURE.
  - Else, counter==TIMEOUT-1 -> set o_timeout_mask[index], go to RELEASE.
  - Else counter increments.
- CAPTURE: push i_frame every cycle i_writing=1; i_writing=0 -> RELEASE (that cycle pushes nothing).
- RELEASE: select=IDLE_ID for exactly one cycle, then DRAIN. The controllers arm on a rising match, so this gap is mandatory between consecutive IDs.
- DRAIN: select=IDLE_ID; wait until the FIFO is empty.
  - Then index==N_CTRL-1 -> DONE.
  - Otherwise index++ and go to SELECT.
- DONE: o_done=1 for one cycle, then IDLE.
- Push while full: frame dropped, o_overflow set, FIFO unchanged. Push and pop in the same cycle when full is a legal push, since the pop frees the slot.
- FIFO latency: a frame pushed at edge t is visible on o_frame with o_frame_valid=1 after edge t+1. Frames leave in push order.
- o_frame and o_frame_valid are independent of i_frame_ready; o_frame is stable while valid&!ready.
- i_start during o_busy=1 has no effect.
- i_writing outside WAIT_WR/CAPTURE is ignored (no push).
- Index arithmetic: BASE_ID+index is truncated to NB_ID bits. Configurations where BASE_ID+N_CTRL-1 reaches IDLE_ID are illegal; flag them with an elaboration-time check.
- Pointers: FIFO read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the rest are equal; empty when all bits are equal.

Decomposition:
- Shared debug package holds:
  - state encoding localparams;
  - IDLE_ID;
  - the controller ID map (CONTROLLER_ID values of all latch instances), which is also used by the top-level instantiation.
- One sub-module: debug_frame_fifo. Synchronous single-clock FIFO, parameters NB_DATA and DEPTH. Ports: push, data, full, pop, data, empty; same reset convention (i_reset_n).

Test Plan:
1. N_CTRL=2, controllers streaming 1 and 2 frames (0xAAAA0001; 0xBBBB0001, 0xBBBB0002), i_frame_ready=1 -> o_request_select sequence IDLE, 0x00, 0x3F, 0x01, 0x3F. o_frame outputs those 3 values in order. o_done pulses once; o_timeout_mask=0.
2. Controller 1 never asserts i_writing, TIMEOUT=255 -> select 0x01 held for exactly 255 cycles after SELECT, then o_timeout_mask=2'b10. The sequence still completes with o_done.
3. i_frame_ready=0 throughout a 4-frame capture, FIFO_DEPTH=8 -> o_frame_valid=1 and o_frame=first frame, stable. The state stays in DRAIN and the next select is not issued until 4 pops occur.
4. FIFO_DEPTH=2, a controller streams 3 frames with ready=0 -> frames 1-2 retained, frame 3 dropped, o_overflow=1 until the next i_start.
5. i_reset_n=0 during CAPTURE with 2 frames buffered -> next cycle o_request_select=0x3F, o_frame_valid=0, o_busy=0, o_overflow=0.
6. i_start pulsed again while o_busy=1 -> no restart; exactly one o_done pulse for the sequence.
